uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter driven by the UART control FSM's one-cycle send strobe.
- Latches one byte and shifts it out 8N1, LSB first, on tx_o.
- ready_o is high only while idle; the control FSM waits on it, then clears the control register.
- Sits between the control FSM / data register and the board TX pin; runs on the 10 MHz system clock.

Parameters:
- CLK_FREQ, 10_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- Derived local constant CLKS_PER_BIT = CLK_FREQ/BAUD, integer truncation (1041 at defaults).
- CLKS_PER_BIT must be >= 2; elaboration error otherwise.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- send_i  in  1  start strobe; sampled only in IDLE.
- data_i  in  8  byte to transmit; captured on the accepting edge.
- tx_o  out  1  serial line, idle high.
- ready_o  out  1  1 = IDLE and able to accept send_i.
- busy_o  out  1  inverse of ready_o; provided for the status register.

Behaviour:
- Reset: while rst_i=1, asynchronously force state=IDLE, tx_o=1, ready_o=1, busy_o=0, baud counter=0, bit index=0, shift register=0.
- State register: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled). tx_o is a registered output.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. "Bit end" = counter at CLKS_PER_BIT-1. The counter wraps to 0 at bit end and is held at 0 in IDLE.
- IDLE -> START: on a clock edge with send_i=1.
  - On that edge: data_i is latched, tx_o goes 0, ready_o goes 0.
  - Zero-cycle latency from the accepting edge to the start bit.
- START -> DATA: at bit end. tx_o = shift[0], bit index = 0.
- DATA:
  - At each bit end, shift right and increment the bit index.
  - After bit 7's bit end, move to STOP with tx_o=1.
  - Bits go out LSB first, each exactly CLKS_PER_BIT cycles.
- STOP -> IDLE: at bit end. ready_o goes 1 on that same edge.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the accepting edge to ready_o rising.
- ready_o is decoded from the state register only; no combinational path from send_i.
- send_i while not IDLE is ignored. Nothing is queued, and data_i changes mid-frame do not affect the frame.
- Back-to-back: send_i held high is accepted again on the edge after ready_o rises. This gives a one-cycle idle-high gap; stop bit length stays unaffected.
- Interaction with the control FSM: its one-cycle strobe lands on the accepting edge, so ready_o is already 0 when the FSM enters its wait state. ready_o returning to 1 marks completion.
- Reset mid-frame: the frame is aborted immediately, tx_o returns high asynchronously, and no partial resume occurs after reset is released.
- Illegal/unused state encodings recover to IDLE with tx_o=1 on the next edge.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_o = even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, frame = 10*CLKS_PER_BIT cycles, 8N1 only.
- Ports and parameters are identical in both builds.

Test Plan (CLK_FREQ=10_000_000, BAUD=1_000_000, CLKS_PER_BIT=10 unless noted):
- Reset: rst_i pulsed asynchronously between edges -> tx_o=1, ready_o=1, busy_o=0 immediately; stay so with send_i=0 for 100 cycles.
- Single frame: data_i=0xA5, one-cycle send_i -> tx_o low from the accepting edge for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high; ready_o rises exactly 100 cycles after acceptance.
- Ignored send: send_i pulsed 35 cycles into a 0x3C frame with data_i=0xFF -> line still carries 0x3C; frame still ends at cycle 100.
- Back-to-back: send_i held high with data_i=0x55 then 0xAA -> two frames, second start bit begins 1 cycle after ready_o rises, both decoded correctly.
- Reset mid-frame: rst_i asserted at cycle 47 of a 0x0F frame -> tx_o=1 and ready_o=1 immediately. After release, a new 0x81 frame transmits correctly from the start.
- Parity (UART_TX_PARITY_EN defined): 0x07 -> parity bit 1; 0xA5 -> parity bit 0; ready_o rises 110 cycles after acceptance.

Source files
------------

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module      : uart_tx_if
// Description : Send/accept handshake between the UART control FSM and uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;
  logic       send_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       busy_o;

  modport master (output send_i, output data_i, input ready_o, input busy_o);
  modport slave  (input send_i, input data_i, output ready_o, output busy_o);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter, LSB first, zero-latency start bit.
//               Optional even parity bit when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  wire       clk_i,
  input  wire       rst_i,
  uart_tx_if.slave  bus,
  output logic      tx_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  generate
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,S_PARITY = 3'd4
`endif
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             ready_q;
  logic             busy_q;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign cnt_d   = ((state_q == S_IDLE) || bit_end) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          // Start bit goes out on the accepting edge itself.
          if (bus.send_i) begin
            state_q  <= S_START;
            shift_q  <= bus.data_i;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^bus.data_i;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
            idx_q   <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o        = tx_q;
  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx at 10 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  int   checks = 0;
  int   errors = 0;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ (10_000_000),
    .BAUD     (1_000_000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .tx_o  (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level k cycles after the accepting edge of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at the sample point just after the accepting edge; returns at the
  // sample point FRAME cycles later, where ready must have risen.
  task automatic check_frame(input logic [7:0] b, input int poke, input string tag);
    for (int k = 0; k < FRAME; k++) begin
      chk({tag, " tx"}, {31'd0, tx}, {31'd0, exp_bit(b, k)});
      chk({tag, " ready"}, {31'd0, bus.ready_o}, 32'd0);
      chk({tag, " busy"}, {31'd0, bus.busy_o}, 32'd1);
      if (poke >= 0 && k == poke) begin
        bus.send_i = 1'b1;
        bus.data_i = 8'hFF;
      end else if (poke >= 0 && k == poke + 1) begin
        bus.send_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk({tag, " end tx"}, {31'd0, tx}, 32'd1);
    chk({tag, " end ready"}, {31'd0, bus.ready_o}, 32'd1);
    chk({tag, " end busy"}, {31'd0, bus.busy_o}, 32'd0);
  endtask

  task automatic start_frame(input logic [7:0] b);
    bus.data_i = b;
    bus.send_i = 1'b1;
    @(posedge clk); #1;
    bus.send_i = 1'b0;
  endtask

  initial begin
    bus.send_i = 1'b0;
    bus.data_i = 8'h00;

    // Reset state, then an asynchronous pulse between edges
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst ready", {31'd0, bus.ready_o}, 32'd1);
    chk("rst busy", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst tx", {31'd0, tx}, 32'd1);
    chk("async rst ready", {31'd0, bus.ready_o}, 32'd1);
    chk("async rst busy", {31'd0, bus.busy_o}, 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("idle tx", {31'd0, tx}, 32'd1);
      chk("idle ready", {31'd0, bus.ready_o}, 32'd1);
    end

    // Single frames
    start_frame(8'hA5);
    check_frame(8'hA5, -1, "a5");
    @(posedge clk); #1;
    chk("a5 stays idle", {31'd0, tx}, 32'd1);

    start_frame(8'h07);
    check_frame(8'h07, -1, "07");

    // Send strobe mid-frame is ignored
    start_frame(8'h3C);
    check_frame(8'h3C, 35, "3c ignored send");
    @(posedge clk); #1;
    chk("3c no requeue tx", {31'd0, tx}, 32'd1);
    chk("3c no requeue ready", {31'd0, bus.ready_o}, 32'd1);

    // Back-to-back with send held high; data change mid-frame must not leak
    bus.data_i = 8'h55;
    bus.send_i = 1'b1;
    @(posedge clk); #1;
    bus.data_i = 8'hAA;
    check_frame(8'h55, -1, "b2b 55");
    @(posedge clk); #1;
    bus.send_i = 1'b0;
    check_frame(8'hAA, -1, "b2b aa");

    // Reset mid-frame, then a clean frame from the start
    start_frame(8'h0F);
    repeat (47) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("mid rst tx", {31'd0, tx}, 32'd1);
    chk("mid rst ready", {31'd0, bus.ready_o}, 32'd1);
    chk("mid rst busy", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("post rst idle tx", {31'd0, tx}, 32'd1);
      chk("post rst idle ready", {31'd0, bus.ready_o}, 32'd1);
    end
    start_frame(8'h81);
    check_frame(8'h81, -1, "81 after rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
